// File: rtl/rb_controller.sv
// rb_controller: sequencer that decodes 16-bit instructions into register-bank write controls.
// Optional accepted-instruction counter enabled by RB_CONTROLLER_INSTR_COUNT_EN.
module rb_controller #(
    parameter int ALU_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        WE,
    output logic [3:0]  RegAdd,
    output logic [2:0]  InMuxAdd,
    output logic [3:0]  OutMuxAdd,
    output logic [7:0]  CUconst,
    output logic [3:0]  ALUsel,
    output logic        out_strobe,
    output logic        halted,
    output logic        illegal,
    output logic [7:0]  instr_count
);
    typedef enum logic [2:0] {IDLE, EXEC, AWAIT, WB, HALT} state_t;

    // EXEC already accounts for one wait cycle, AWAIT covers the rest
    localparam logic [2:0] WAIT_LOAD = ALU_WAIT > 1 ? 3'(ALU_WAIT - 2) : 3'd0;

    state_t      r_state, w_next;
    logic [15:0] r_ir;
    logic [2:0]  r_cnt;
    logic        r_illegal, r_strobe, r_armed;
    logic [3:0]  w_op;
    logic        w_accept, w_wr_op, w_rb_op;

    assign w_op        = r_ir[15:12];
    assign instr_ready = r_armed && r_state == IDLE;
    assign w_accept    = instr_ready && instr_valid;
    assign w_rb_op     = w_op == 4'd4 || w_op == 4'd6;
    assign w_wr_op     = (w_op >= 4'd1 && w_op <= 4'd4) || w_op == 4'd6;
    assign halted      = r_state == HALT;
    assign illegal     = r_illegal;
    assign out_strobe  = r_strobe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_strobe  <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_armed  <= 1'b1;
            r_state  <= w_next;
            r_strobe <= r_state == EXEC && w_op == 4'd6;
            if (w_accept) begin
                r_ir <= instr;
                if (instr[15]) r_illegal <= 1'b1;
            end
            if (r_state == EXEC) r_cnt <= WAIT_LOAD;
            else if (r_state == AWAIT) r_cnt <= r_cnt - 3'd1;
        end
    end

    always_comb begin
        w_next    = r_state;
        WE        = 1'b0;
        RegAdd    = '0;
        InMuxAdd  = '0;
        OutMuxAdd = '0;
        CUconst   = '0;
        ALUsel    = '0;
        case (r_state)
            IDLE: w_next = w_accept ? EXEC : IDLE;
            EXEC: begin
                w_next    = w_op == 4'd7 ? HALT :
                            w_op == 4'd5 ? (ALU_WAIT > 1 ? AWAIT : WB) : IDLE;
                WE        = w_wr_op;
                RegAdd    = (w_wr_op && w_op != 4'd6) ? r_ir[11:8] : 4'd0;
                InMuxAdd  = w_op == 4'd2 ? 3'd1 : w_op == 4'd3 ? 3'd2 : w_rb_op ? 3'd4 : 3'd0;
                OutMuxAdd = w_rb_op ? r_ir[7:4] : 4'd0;
                CUconst   = w_op == 4'd3 ? r_ir[7:0] : 8'd0;
                ALUsel    = w_op == 4'd5 ? r_ir[3:0] : 4'd0;
            end
            AWAIT: begin
                w_next = r_cnt == 3'd0 ? WB : AWAIT;
                ALUsel = r_ir[3:0];
            end
            WB: begin
                w_next   = IDLE;
                WE       = 1'b1;
                RegAdd   = r_ir[11:8];
                InMuxAdd = 3'd3;
                ALUsel   = r_ir[3:0];
            end
            default: w_next = HALT;
        endcase
    end

`ifdef RB_CONTROLLER_INSTR_COUNT_EN
    logic [7:0] r_count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_count <= '0;
        else if (w_accept) r_count <= r_count + 8'd1;
    end
    assign instr_count = r_count;
`else
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_rb_controller.sv
// tb_rb_controller: scoreboard bench for rb_controller; expected writes are queued at
// issue time and retired when the DUT raises WE or out_strobe.
module tb_rb_controller;
    localparam int W = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready, WE, out_strobe, halted, illegal;
    logic [3:0]  RegAdd, OutMuxAdd, ALUsel;
    logic [2:0]  InMuxAdd;
    logic [7:0]  CUconst, instr_count;

    rb_controller #(.ALU_WAIT(W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .WE(WE), .RegAdd(RegAdd), .InMuxAdd(InMuxAdd),
        .OutMuxAdd(OutMuxAdd), .CUconst(CUconst), .ALUsel(ALUsel),
        .out_strobe(out_strobe), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [22:0] f;
    } exp_t;

    exp_t       sb[$];
    int         sq[$];
    exp_t       me;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         next_acc = 0;
    logic [7:0] cnt_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_count();
`ifdef RB_CONTROLLER_INSTR_COUNT_EN
        return cnt_exp;
`else
        return 8'd0;
`endif
    endfunction

    // fields packed as {RegAdd, InMuxAdd, OutMuxAdd, CUconst, ALUsel}
    task automatic model(input logic [15:0] ins, output bit wr, output logic [22:0] f, output int lat);
        logic [3:0] rd;
        logic [7:0] imm;
        rd  = ins[11:8];
        imm = ins[7:0];
        wr  = 1'b1;
        lat = 1;
        f   = '0;
        case (ins[15:12])
            4'd1: f = {rd, 3'd0, 4'd0, 8'd0, 4'd0};
            4'd2: f = {rd, 3'd1, 4'd0, 8'd0, 4'd0};
            4'd3: f = {rd, 3'd2, 4'd0, imm, 4'd0};
            4'd4: f = {rd, 3'd4, imm[7:4], 8'd0, 4'd0};
            4'd6: f = {4'd0, 3'd4, imm[7:4], 8'd0, 4'd0};
            4'd5: begin f = {rd, 3'd3, 4'd0, 8'd0, imm[3:0]}; lat = 1 + W; end
            default: wr = 1'b0;
        endcase
    endtask

    always @(negedge clk) begin
        if (WE) begin
            if (sb.size() == 0) check("spurious_we", 1, 0);
            else begin
                me = sb.pop_front();
                check("we_edge", cyc + 1, me.e);
                check("we_fields", {RegAdd, InMuxAdd, OutMuxAdd, CUconst, ALUsel}, me.f);
            end
        end
        if (out_strobe) begin
            if (sq.size() == 0) check("spurious_strobe", 1, 0);
            else check("strobe_cyc", cyc, sq.pop_front());
        end
    end

    task automatic issue(input logic [15:0] ins, input bit lat_chk);
        int          k, n, lat;
        bit          wr;
        logic [22:0] f;
        k = 0;
        @(negedge clk);
        while (!instr_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        if (lat_chk) check("accept_edge", cyc + 1, next_acc);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1;
        n           = cyc;
        instr_valid = 1'b0;
        instr       = '0;
        cnt_exp     = cnt_exp + 8'd1;
        model(ins, wr, f, lat);
        if (wr) sb.push_back('{e: n + lat, f: f});
        if (ins[15:12] == 4'd6) sq.push_back(n + 1);
        next_acc = n + 1 + lat;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_outs", {instr_ready, WE, RegAdd, InMuxAdd, OutMuxAdd, CUconst, ALUsel,
                           out_strobe, halted, illegal, instr_count}, 0);
        sb.delete();
        sq.delete();
        cnt_exp = '0;
        @(negedge clk);
        check("rst_held_ready", instr_ready, 0);
        reset = 1'b1;
        #1 check("ready_before_edge", instr_ready, 0);
        @(posedge clk);
        #1 check("ready_after_edge", instr_ready, 1);
    endtask

    initial begin
        #3;
        check("init_outs", {instr_ready, WE, RegAdd, InMuxAdd, OutMuxAdd, CUconst, ALUsel,
                            out_strobe, halted, illegal, instr_count}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("ready_before_edge", instr_ready, 0);
        @(posedge clk);
        #1 check("ready_after_edge", instr_ready, 1);

        issue(16'h335A, 0);
        @(negedge clk);
        check("ldi_ready_low", instr_ready, 0);
        check("ldi_we", WE, 1);
        foreach (sb[i]) check("ldi_pending", sb.size(), 1);
        issue(16'h1100, 1);
        issue(16'h2200, 1);
        issue(16'h4430, 1);
        issue(16'h6090, 1);
        issue(16'h1000, 1);
        issue(16'h5742, 1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("alu_sel", ALUsel, 4'd2);
            check("alu_we_low", WE, 0);
        end
        issue(16'h0000, 1);
        issue(16'h60F0, 1);
        issue(16'h5A13, 1);
        @(negedge clk);
        check("count_mid", instr_count, exp_count());

        issue(16'hB000, 1);
        issue(16'h7000, 1);
        instr_valid = 1'b1;
        instr       = 16'h1100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("halt_ready", instr_ready, 0);
        end
        instr_valid = 1'b0;
        instr       = '0;
        check("halt_flags", {halted, illegal}, 2'b11);
        check("count_halt", instr_count, exp_count());

        do_reset();
        check("flags_cleared", {halted, illegal, out_strobe}, 0);
        issue(16'h5742, 0);
        @(posedge clk);
        do_reset();
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("abort_no_we", WE, 0);
        check("abort_flags", {halted, illegal, out_strobe, instr_count}, 0);

        for (int i = 0; i < 256; i++) issue(16'h0000, i != 0);
        @(negedge clk);
        check("count_wrap", instr_count, exp_count());
        issue(16'h3801, 1);
        repeat (W + 3) @(negedge clk);
        check("count_post", instr_count, exp_count());
        check("sb_drained", sb.size(), 0);
        check("strobe_drained", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
